// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared fetch-stage defines, bus widths and fetch FSM encodings.
package inst_fetch_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus = 32;
  localparam logic RstEnable = 1'b1;
  localparam logic Stop = 1'b1;
  localparam logic NoStop = 1'b0;
  localparam logic [InstBus-1:0] ZeroWord = '0;
  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstBus-1:0] inst_t;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } fetch_state_e;
  function automatic inst_addr_t next_seq_pc(input inst_addr_t pc);
    return pc + inst_addr_t'(4);
  endfunction
endpackage

// File: rtl/inst_fetch_wb_if.sv
// inst_wb_if: single-outstanding Wishbone instruction fetch FSM with a read buffer for stalled pipelines.
module inst_wb_if import inst_fetch_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall,
  input  logic       flush,
  input  inst_addr_t pc_i,
  input  inst_t      wb_dat_i,
  input  logic       wb_ack_i,
  output inst_addr_t wb_adr_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output inst_t      inst_o,
  output logic       stallreq_o
);
  fetch_state_e state_q, state_d;
  inst_addr_t adr_q, adr_d;
  inst_t buf_q, buf_d;
  logic cyc_q, cyc_d;
  always_ff @(posedge clk) begin
    if (rst == RstEnable) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = flush ? IDLE : BUSY;
      BUSY:       state_d = flush ? IDLE : !wb_ack_i ? BUSY : (|stall) ? WAIT_STALL : IDLE;
      WAIT_STALL: state_d = (flush || stall == 6'd0) ? IDLE : WAIT_STALL;
      default:    state_d = IDLE;
    endcase
  end
  // Address is captured only at launch so it stays stable for the whole bus cycle.
  always_comb begin
    adr_d = (state_q == IDLE && !flush) ? pc_i : adr_q;
    cyc_d = state_d == BUSY;
    buf_d = (state_q == BUSY && wb_ack_i && !flush) ? wb_dat_i : buf_q;
    stallreq_o = (rst != RstEnable) && !flush && (state_q == IDLE || (state_q == BUSY && !wb_ack_i));
    inst_o = (rst == RstEnable) ? ZeroWord
           : (state_q == BUSY && wb_ack_i) ? wb_dat_i
           : (state_q == WAIT_STALL) ? buf_q : ZeroWord;
  end
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      adr_q <= '0;
      cyc_q <= 1'b0;
      buf_q <= ZeroWord;
    end else begin
      adr_q <= adr_d;
      cyc_q <= cyc_d;
      buf_q <= buf_d;
    end
  end
  assign wb_adr_o = adr_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: program counter and Wishbone instruction fetch front end.
module inst_fetch import inst_fetch_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic [31:0] wb_adr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        stallreq_o
);
  inst_addr_t pc_q, pc_d;
  always_comb begin
    pc_d = flush ? new_pc
         : (stall[0] == Stop) ? pc_q
         : branch_flag_i ? branch_target_i
         : next_seq_pc(pc_q);
  end
  always_ff @(posedge clk) begin
    if (rst == RstEnable) pc_q <= '0;
    else pc_q <= pc_d;
  end
  inst_wb_if u_wb_if (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .pc_i       (pc_q),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_adr_o   (wb_adr_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .inst_o     (inst_o),
    .stallreq_o (stallreq_o)
  );
  assign pc_o = pc_q;
  assign wb_we_o = 1'b0;
  assign wb_sel_o = 4'b1111;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a transaction-level fetch model.
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] stall = '0;
  logic flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic br = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] dat = '0;
  logic ack = 1'b0;
  logic [31:0] wb_adr_o, pc_o, inst_o;
  logic wb_cyc_o, wb_stb_o, wb_we_o, stallreq_o;
  logic [3:0] wb_sel_o;
  int checks = 0;
  int errors = 0;
  // model: m_busy = bus cycle outstanding, m_hold = fetched word parked while pipeline stalls
  logic [31:0] m_pc = '0, m_adr = '0, m_buf = '0;
  logic m_busy = 1'b0, m_hold = 1'b0;

  inst_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(br), .branch_target_i(tgt), .wb_dat_i(dat), .wb_ack_i(ack),
    .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .pc_o(pc_o), .inst_o(inst_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  function automatic logic exp_stallreq();
    return !rst && !flush && ((!m_busy && !m_hold) || (m_busy && !ack));
  endfunction

  function automatic logic [31:0] exp_inst();
    return rst ? 32'h0 : (m_busy && ack) ? dat : m_hold ? m_buf : 32'h0;
  endfunction

  task automatic tick();
    logic [31:0] old_pc;
    @(posedge clk);
    old_pc = m_pc;
    if (rst) begin
      m_pc = '0; m_adr = '0; m_buf = '0; m_busy = 1'b0; m_hold = 1'b0;
    end else begin
      m_pc = flush ? new_pc : stall[0] ? m_pc : br ? tgt : m_pc + 32'd4;
      if (m_hold) m_hold = !(flush || stall == 6'd0);
      else if (m_busy) begin
        if (!flush && ack) begin
          m_buf = dat;
          m_hold = stall != 6'd0;
        end
        if (flush || ack) m_busy = 1'b0;
      end else if (!flush) begin
        m_busy = 1'b1;
        m_adr = old_pc;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = '0; flush = 1'b0; br = 1'b0; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ack = 1'b1; dat = 32'hDEADBEEF;
    tick();
    #1;
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_o, 32'h0); end
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b%b exp 00", wb_cyc_o, wb_stb_o); end
    checks++; if (wb_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr got %h exp %h", wb_adr_o, 32'h0); end
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stallreq got %b exp 0", stallreq_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp %h", inst_o, 32'h0); end
    checks++; if (wb_we_o !== 1'b0 || wb_sel_o !== 4'hF) begin errors++; $display("FAIL reset_we_sel got %b %h exp 0 f", wb_we_o, wb_sel_o); end
    ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    stall = 6'h0F; #1;
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL basic_idle_stallreq got %b exp 1", stallreq_o); end
    tick();
    ack = 1'b1; dat = 32'h24010001; stall = '0; #1;
    checks++; if (wb_adr_o !== 32'h0 || wb_cyc_o !== 1'b1) begin errors++; $display("FAIL basic_launch got %h/%b exp 00000000/1", wb_adr_o, wb_cyc_o); end
    checks++; if (inst_o !== 32'h24010001 || pc_o !== 32'h0) begin errors++; $display("FAIL basic_ack_inst got %h@%h exp 24010001@00000000", inst_o, pc_o); end
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL basic_ack_stallreq got %b exp 0", stallreq_o); end
    tick();
    ack = 1'b0; stall = 6'h0F; #1;
    checks++; if (wb_cyc_o !== 1'b0 || pc_o !== 32'h4) begin errors++; $display("FAIL basic_after_ack got %b/%h exp 0/00000004", wb_cyc_o, pc_o); end
    tick(); #1;
    checks++; if (wb_adr_o !== 32'h4 || wb_cyc_o !== 1'b1) begin errors++; $display("FAIL basic_second_adr got %h/%b exp 00000004/1", wb_adr_o, wb_cyc_o); end
  endtask

  task automatic test_delayed_ack();
    logic [31:0] d;
    do_reset();
    stall = 6'h0F; #1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stallreq_o !== 1'b1 || wb_cyc_o !== 1'b1) begin errors++; $display("FAIL delay_busy%0d got %b/%b exp 1/1", i, stallreq_o, wb_cyc_o); end
      checks++; if (wb_adr_o !== 32'h0 || pc_o !== 32'h0) begin errors++; $display("FAIL delay_hold%0d got %h/%h exp 0/0", i, wb_adr_o, pc_o); end
      tick();
    end
    d = $urandom; ack = 1'b1; dat = d; stall = '0; #1;
    checks++; if (inst_o !== d || stallreq_o !== 1'b0) begin errors++; $display("FAIL delay_ack got %h/%b exp %h/0", inst_o, stallreq_o, d); end
    tick();
    ack = 1'b0;
  endtask

  task automatic test_wait_stall();
    logic [31:0] d;
    do_reset();
    stall = 6'h0F; #1;
    tick();
    d = $urandom; ack = 1'b1; dat = d; stall = 6'b000111; #1;
    tick();
    ack = 1'b0; dat = ~d;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (inst_o !== d) begin errors++; $display("FAIL wstall_inst%0d got %h exp %h", i, inst_o, d); end
      checks++; if (wb_cyc_o !== 1'b0 || stallreq_o !== 1'b0 || pc_o !== 32'h0) begin errors++; $display("FAIL wstall_ctl%0d got %b/%b/%h exp 0/0/0", i, wb_cyc_o, stallreq_o, pc_o); end
      tick();
    end
    stall = '0; #1;
    checks++; if (inst_o !== d) begin errors++; $display("FAIL wstall_release_inst got %h exp %h", inst_o, d); end
    tick(); #1;
    checks++; if (inst_o !== 32'h0 || stallreq_o !== 1'b1 || pc_o !== 32'h4) begin errors++; $display("FAIL wstall_idle got %h/%b/%h exp 0/1/4", inst_o, stallreq_o, pc_o); end
  endtask

  task automatic test_flush();
    do_reset();
    stall = 6'h0F; #1;
    tick();
    flush = 1'b1; new_pc = 32'h180; ack = 1'b1; dat = $urandom; stall = '0; #1;
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_stallreq got %b exp 0", stallreq_o); end
    tick();
    flush = 1'b0; ack = 1'b0; stall = 6'h0F; #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL flush_drop got %b%b exp 00", wb_cyc_o, wb_stb_o); end
    checks++; if (pc_o !== 32'h180 || inst_o !== 32'h0) begin errors++; $display("FAIL flush_pc got %h/%h exp 00000180/0", pc_o, inst_o); end
    tick(); #1;
    checks++; if (wb_adr_o !== 32'h180 || wb_cyc_o !== 1'b1) begin errors++; $display("FAIL flush_refetch got %h/%b exp 00000180/1", wb_adr_o, wb_cyc_o); end
  endtask

  task automatic test_branch();
    do_reset();
    br = 1'b1; tgt = 32'h40; stall = '0; #1;
    tick();
    br = 1'b0; #1;
    checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL branch_pc got %h exp 00000040", pc_o); end
    flush = 1'b1; new_pc = 32'hFFFFFFFC;
    tick();
    flush = 1'b0; #1;
    checks++; if (pc_o !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_setup got %h exp fffffffc", pc_o); end
    tick(); #1;
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 00000000", pc_o); end
    br = 1'b1; tgt = 32'h80; stall = 6'h01;
    tick(); #1;
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL stall_over_branch got %h exp 00000000", pc_o); end
    br = 1'b0; stall = '0;
  endtask

  task automatic test_rst_busy();
    do_reset();
    stall = 6'h0F; #1;
    tick(); #1;
    checks++; if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL rstbusy_pre got %b exp 1", wb_cyc_o); end
    rst = 1'b1; #1;
    checks++; if (stallreq_o !== 1'b0 || inst_o !== 32'h0) begin errors++; $display("FAIL rstbusy_during got %b/%h exp 0/0", stallreq_o, inst_o); end
    tick();
    rst = 1'b0; ack = 1'b1; dat = 32'h12345678; #1;
    checks++; if (wb_cyc_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0) begin errors++; $display("FAIL rstbusy_after got %b/%h/%h exp 0/0/0", wb_cyc_o, pc_o, inst_o); end
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL rstbusy_idle got %b exp 1", stallreq_o); end
    tick();
    ack = 1'b0; #1;
    checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h0) begin errors++; $display("FAIL rstbusy_relaunch got %b/%h exp 1/0", wb_cyc_o, wb_adr_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom % 50) == 0;
      flush = ($urandom % 12) == 0;
      new_pc = {$urandom, 2'b00} >> 0;
      br = ($urandom % 4) == 0;
      tgt = $urandom & 32'hFFFFFFFC;
      ack = $urandom % 2;
      dat = $urandom;
      stall = ($urandom % 3 == 0) ? 6'($urandom) : (exp_stallreq() ? 6'h0F : 6'h00);
      #1;
      checks++; if (pc_o !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, pc_o, m_pc); end
      checks++; if (wb_cyc_o !== m_busy || wb_stb_o !== m_busy) begin errors++; $display("FAIL rnd_cyc[%0d] got %b%b exp %b", i, wb_cyc_o, wb_stb_o, m_busy); end
      checks++; if (wb_adr_o !== m_adr) begin errors++; $display("FAIL rnd_adr[%0d] got %h exp %h", i, wb_adr_o, m_adr); end
      checks++; if (stallreq_o !== exp_stallreq()) begin errors++; $display("FAIL rnd_stallreq[%0d] got %b exp %b", i, stallreq_o, exp_stallreq()); end
      checks++; if (inst_o !== exp_inst()) begin errors++; $display("FAIL rnd_inst[%0d] got %h exp %h", i, inst_o, exp_inst()); end
      checks++; if (wb_we_o !== 1'b0 || wb_sel_o !== 4'hF) begin errors++; $display("FAIL rnd_we_sel[%0d] got %b %h exp 0 f", i, wb_we_o, wb_sel_o); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_ack();
    test_wait_stall();
    test_flush();
    test_branch();
    test_rst_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall  in  6  pipeline stall vector; bit0 = PC stage, 1 = Stop
- flush  in  1  exception flush
- new_pc  in  32  exception handler address
- branch_flag_i  in  1  branch taken (from decode)
- branch_target_i  in  32  branch target address
- wb_dat_i  in  32  instruction read data
- wb_ack_i  in  1  bus acknowledge
- wb_adr_o  out  32  bus address
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  bus strobe
- wb_we_o  out  1  write enable, constant 0
- wb_sel_o  out  4  byte select, constant 4'b1111
- pc_o  out  32  address of inst_o, to IF/ID register
- inst_o  out  32  fetched instruction, to IF/ID register
- stallreq_o  out  1  fetch stall request to pipeline control

Function
REQ-003 pc_o SHALL update on rising clk; priority order: rst > flush > stall[0]==Stop > branch > sequential.
REQ-004 flush SHALL load new_pc into pc_o.
REQ-005 If stall[0]==Stop, pc_o SHALL hold.
REQ-006 With branch_flag_i=1 and no stall, pc_o SHALL load branch_target_i.
REQ-007 Otherwise pc_o SHALL load pc_o+4, truncated to 32 bits (0xFFFFFFFC wraps to 0x00000000).
REQ-008 The fetch FSM SHALL have three states, and no others:
- IDLE
- BUSY
- WAIT_STALL
REQ-009 IDLE with flush=0: the FSM SHALL start a bus cycle next edge (wb_adr_o<=pc_o, wb_cyc_o=wb_stb_o<=1) and go to BUSY.
REQ-010 BUSY with wb_ack_i=1 and flush=0: the FSM SHALL drop cyc/stb and capture wb_dat_i into a read buffer.
- Next state is WAIT_STALL if stall!=0, else IDLE.
REQ-011 BUSY with flush=1: the FSM SHALL drop cyc/stb, discard any data, go to IDLE; flush wins over a simultaneous ack.
REQ-012 WAIT_STALL: the FSM SHALL return to IDLE when stall==0 or flush=1, and hold otherwise.
REQ-013 stallreq_o (combinational) SHALL be:
- 1 in IDLE with flush=0
- 1 in BUSY with wb_ack_i=0 and flush=0
- 0 otherwise
REQ-014 inst_o (combinational) SHALL be:
- wb_dat_i in BUSY when wb_ack_i=1
- read buffer in WAIT_STALL
- 0x00000000 (NOP) otherwise
REQ-015 wb_adr_o SHALL remain stable from cycle start until ack or abort.
REQ-016 Minimum fetch latency SHALL be 2 cycles per instruction: IDLE launch, then BUSY with ack in the same cycle.
REQ-017 The block SHALL never issue more than one outstanding bus cycle.

Reset
REQ-018 On rst, the following SHALL clear:
- pc_o = 0x00000000
- FSM = IDLE
- wb_adr_o = 0, wb_cyc_o = 0, wb_stb_o = 0
- read buffer = 0
REQ-019 rst asserted mid bus cycle SHALL drop cyc/stb at that edge; a late ack is ignored.
REQ-020 During rst, stallreq_o=0 and inst_o=0.

Structure
REQ-021 The following SHALL live in the shared defines file, not in this module:
- ZeroWord, RstEnable, Stop/NoStop
- InstAddrBus/InstBus widths
- FSM state encodings
REQ-022 The bus FSM SHALL be a sub-module inst_wb_if; pc logic stays in the top level.

Verification
REQ-023 Release rst; slave acks in 1 cycle, data 0x24010001 -> wb_adr_o=0x0 then 0x4; inst_o=0x24010001 with pc_o=0x0 in ack cycle; stallreq_o drops on ack.
REQ-024 Ack delayed 3 cycles -> stallreq_o=1 for 3 BUSY cycles; pc_o held via stall[0]=1; wb_adr_o constant.
REQ-025 Ack arrives with stall=6'b000111 for 2 cycles -> FSM in WAIT_STALL; inst_o=latched data for both cycles; IDLE after stall clears.
REQ-026 flush=1, new_pc=0x00000180 during BUSY with simultaneous ack -> cyc/stb=0 next edge; data discarded; pc_o=0x180; next fetch address 0x180.
REQ-027 branch_flag_i=1, target 0x00000040, stall=0 -> pc_o=0x40 next edge; pc_o=0xFFFFFFFC sequential -> 0x0.
REQ-028 rst asserted in BUSY -> cyc/stb=0, pc_o=0, FSM IDLE next edge; ack in the following cycle has no effect.
